// File: rtl/id_ex_pipe.sv
// Decode-to-execute pipeline register with stall, flush, load-use bubble insertion,
// writeback bypass on capture and while held, and a saturating bubble counter.
module id_ex_pipe #(
    parameter int XLEN   = 32,
    parameter int RA_W   = 5,
    parameter int CTRL_W = 24,
    parameter int CNT_W  = 16
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              FlushE,
    input  logic              StallE,
    input  logic              validD,
    input  logic [RA_W-1:0]   rs1D,
    input  logic [RA_W-1:0]   rs2D,
    input  logic [RA_W-1:0]   rdD,
    input  logic [XLEN-1:0]   RD1D,
    input  logic [XLEN-1:0]   RD2D,
    input  logic [XLEN-1:0]   ImmExtD,
    input  logic [XLEN-1:0]   PCD,
    input  logic [XLEN-1:0]   PCPlus4D,
    input  logic [CTRL_W-1:0] CtrlD,
    input  logic              RegWriteD,
    input  logic              MemWriteD,
    input  logic              LoadD,
    input  logic              RegWriteW,
    input  logic [RA_W-1:0]   rdW,
    input  logic [XLEN-1:0]   ResultW,
    output logic [XLEN-1:0]   RD1E,
    output logic [XLEN-1:0]   RD2E,
    output logic [XLEN-1:0]   ImmExtE,
    output logic [XLEN-1:0]   PCE,
    output logic [XLEN-1:0]   PCPlus4E,
    output logic [RA_W-1:0]   rs1E,
    output logic [RA_W-1:0]   rs2E,
    output logic [RA_W-1:0]   rdE,
    output logic [CTRL_W-1:0] CtrlE,
    output logic              RegWriteE,
    output logic              MemWriteE,
    output logic              LoadE,
    output logic              validE,
    output logic              LoadUseHazard,
    output logic [CNT_W-1:0]  BubbleCnt
);

    typedef struct packed {
        logic [XLEN-1:0]   rd1;
        logic [XLEN-1:0]   rd2;
        logic [XLEN-1:0]   imm;
        logic [XLEN-1:0]   pc;
        logic [XLEN-1:0]   pcPlus4;
        logic [RA_W-1:0]   rs1;
        logic [RA_W-1:0]   rs2;
        logic [RA_W-1:0]   rd;
        logic [CTRL_W-1:0] ctrl;
        logic              regWrite;
        logic              memWrite;
        logic              load;
        logic              valid;
    } stage_t;

    stage_t            e_q, e_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d, cntSat;
    logic              wbActive;
    logic [XLEN-1:0]   byp1, byp2;

    assign wbActive = RegWriteW && (rdW != '0);
    assign byp1     = (wbActive && (rdW == rs1D)) ? ResultW : RD1D;
    assign byp2     = (wbActive && (rdW == rs2D)) ? ResultW : RD2D;
    assign cntSat   = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);

    assign LoadUseHazard = e_q.valid && e_q.load && validD && (e_q.rd != '0) &&
                           ((e_q.rd == rs1D) || (e_q.rd == rs2D));

    // Flush beats stall; a hazard seen while stalled is ignored until E moves.
    always_comb begin
        e_d   = e_q;
        cnt_d = cnt_q;
        if (FlushE) begin
            e_d   = '0;
            cnt_d = cntSat;
        end else if (StallE) begin
            if (wbActive && e_q.valid && (rdW == e_q.rs1)) e_d.rd1 = ResultW;
            if (wbActive && e_q.valid && (rdW == e_q.rs2)) e_d.rd2 = ResultW;
        end else if (LoadUseHazard) begin
            e_d   = '0;
            cnt_d = cntSat;
        end else begin
            e_d.rd1      = byp1;
            e_d.rd2      = byp2;
            e_d.imm      = ImmExtD;
            e_d.pc       = PCD;
            e_d.pcPlus4  = PCPlus4D;
            e_d.rs1      = rs1D;
            e_d.rs2      = rs2D;
            e_d.rd       = rdD;
            e_d.ctrl     = CtrlD;
            e_d.regWrite = RegWriteD;
            e_d.memWrite = MemWriteD;
            e_d.load     = LoadD;
            e_d.valid    = validD;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            e_q   <= '0;
            cnt_q <= '0;
        end else begin
            e_q   <= e_d;
            cnt_q <= cnt_d;
        end
    end

    assign RD1E      = e_q.rd1;
    assign RD2E      = e_q.rd2;
    assign ImmExtE   = e_q.imm;
    assign PCE       = e_q.pc;
    assign PCPlus4E  = e_q.pcPlus4;
    assign rs1E      = e_q.rs1;
    assign rs2E      = e_q.rs2;
    assign rdE       = e_q.rd;
    assign CtrlE     = e_q.ctrl;
    assign RegWriteE = e_q.regWrite;
    assign MemWriteE = e_q.memWrite;
    assign LoadE     = e_q.load;
    assign validE    = e_q.valid;
    assign BubbleCnt = cnt_q;

endmodule

// File: tb/tb_id_ex_pipe.sv
// Scoreboard bench for id_ex_pipe: a behavioural model predicts each E state,
// predictions are queued when stimulus is driven and compared after the edge.
module tb_id_ex_pipe;

    localparam int XLEN = 32, RA_W = 5, CTRL_W = 24, CNT_W = 2;

    logic CLK = 1'b0, RST, FlushE, StallE, validD;
    logic [RA_W-1:0] rs1D, rs2D, rdD, rdW;
    logic [XLEN-1:0] RD1D, RD2D, ImmExtD, PCD, PCPlus4D, ResultW;
    logic [CTRL_W-1:0] CtrlD;
    logic RegWriteD, MemWriteD, LoadD, RegWriteW;
    logic [XLEN-1:0] RD1E, RD2E, ImmExtE, PCE, PCPlus4E;
    logic [RA_W-1:0] rs1E, rs2E, rdE;
    logic [CTRL_W-1:0] CtrlE;
    logic RegWriteE, MemWriteE, LoadE, validE, LoadUseHazard;
    logic [CNT_W-1:0] BubbleCnt;

    id_ex_pipe #(.XLEN(XLEN), .RA_W(RA_W), .CTRL_W(CTRL_W), .CNT_W(CNT_W)) dut (
        .CLK(CLK), .RST(RST), .FlushE(FlushE), .StallE(StallE), .validD(validD),
        .rs1D(rs1D), .rs2D(rs2D), .rdD(rdD), .RD1D(RD1D), .RD2D(RD2D),
        .ImmExtD(ImmExtD), .PCD(PCD), .PCPlus4D(PCPlus4D), .CtrlD(CtrlD),
        .RegWriteD(RegWriteD), .MemWriteD(MemWriteD), .LoadD(LoadD),
        .RegWriteW(RegWriteW), .rdW(rdW), .ResultW(ResultW),
        .RD1E(RD1E), .RD2E(RD2E), .ImmExtE(ImmExtE), .PCE(PCE), .PCPlus4E(PCPlus4E),
        .rs1E(rs1E), .rs2E(rs2E), .rdE(rdE), .CtrlE(CtrlE),
        .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .LoadE(LoadE), .validE(validE),
        .LoadUseHazard(LoadUseHazard), .BubbleCnt(BubbleCnt)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [XLEN-1:0] rd1, rd2, imm, pc, pc4;
        logic [RA_W-1:0] rs1, rs2, rd;
        logic [CTRL_W-1:0] ctrl;
        logic rw, mw, ld, v;
        logic [CNT_W-1:0] cnt;
    } eState_t;

    eState_t model, expQ[$];
    bit modelValid = 1'b0;
    int compared = 0, mismatched = 0;

    task automatic cmp(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic eState_t zeroState(input logic [CNT_W-1:0] c);
        eState_t s;
        s = '{default: '0};
        s.cnt = c;
        return s;
    endfunction

    function automatic logic [CNT_W-1:0] bump(input logic [CNT_W-1:0] c);
        return (c == {CNT_W{1'b1}}) ? c : c + 1'b1;
    endfunction

    function automatic logic modelHazard();
        if (!(model.v && model.ld && validD) || model.rd == 0) return 1'b0;
        return (model.rd == rs1D) || (model.rd == rs2D);
    endfunction

    function automatic eState_t predict();
        eState_t n;
        n = model;
        if (RST) n = zeroState('0);
        else if (FlushE) n = zeroState(bump(model.cnt));
        else if (StallE) begin
            if (RegWriteW && rdW != 0 && model.v && rdW == model.rs1) n.rd1 = ResultW;
            if (RegWriteW && rdW != 0 && model.v && rdW == model.rs2) n.rd2 = ResultW;
        end else if (modelHazard()) n = zeroState(bump(model.cnt));
        else begin
            n.rd1 = (RegWriteW && rdW != 0 && rdW == rs1D) ? ResultW : RD1D;
            n.rd2 = (RegWriteW && rdW != 0 && rdW == rs2D) ? ResultW : RD2D;
            n.imm = ImmExtD; n.pc = PCD; n.pc4 = PCPlus4D;
            n.rs1 = rs1D; n.rs2 = rs2D; n.rd = rdD; n.ctrl = CtrlD;
            n.rw = RegWriteD; n.mw = MemWriteD; n.ld = LoadD; n.v = validD;
        end
        return n;
    endfunction

    task automatic checkOutput(input eState_t e);
        cmp("RD1E", RD1E, e.rd1);       cmp("RD2E", RD2E, e.rd2);
        cmp("ImmExtE", ImmExtE, e.imm); cmp("PCE", PCE, e.pc);
        cmp("PCPlus4E", PCPlus4E, e.pc4);
        cmp("rs1E", 32'(rs1E), 32'(e.rs1)); cmp("rs2E", 32'(rs2E), 32'(e.rs2));
        cmp("rdE", 32'(rdE), 32'(e.rd));    cmp("CtrlE", 32'(CtrlE), 32'(e.ctrl));
        cmp("RegWriteE", 32'(RegWriteE), 32'(e.rw));
        cmp("MemWriteE", 32'(MemWriteE), 32'(e.mw));
        cmp("LoadE", 32'(LoadE), 32'(e.ld));
        cmp("validE", 32'(validE), 32'(e.v));
        cmp("BubbleCnt", 32'(BubbleCnt), 32'(e.cnt));
    endtask

    // One clock: check the hazard output, queue the prediction, then compare after the edge.
    task automatic applyStimulus();
        eState_t e;
        #1;
        if (modelValid) cmp("LoadUseHazard", 32'(LoadUseHazard), 32'(modelHazard()));
        expQ.push_back(predict());
        @(posedge CLK);
        #1;
        e = expQ.pop_front();
        model = e;
        modelValid = 1'b1;
        checkOutput(e);
    endtask

    task automatic clearD();
        FlushE = 0; StallE = 0; validD = 0; rs1D = 0; rs2D = 0; rdD = 0;
        RD1D = 0; RD2D = 0; ImmExtD = 0; PCD = 0; PCPlus4D = 0; CtrlD = 0;
        RegWriteD = 0; MemWriteD = 0; LoadD = 0; RegWriteW = 0; rdW = 0; ResultW = 0;
    endtask

    initial begin
        clearD();
        RST = 1; validD = 1; rs1D = 5'd9; rs2D = 5'd10; rdD = 5'd11;
        RD1D = 32'h1234_5678; RD2D = 32'h9abc_def0; ImmExtD = 32'hffff_0000;
        PCD = 32'h100; PCPlus4D = 32'h104; CtrlD = 24'hFFFFFF;
        RegWriteD = 1; MemWriteD = 1; LoadD = 1;
        @(negedge CLK);
        applyStimulus();
        applyStimulus();
        cmp("resetHazard", 32'(LoadUseHazard), 32'd0);
        cmp("resetCnt", 32'(BubbleCnt), 32'd0);

        RST = 0; clearD();
        validD = 1; rdD = 5'd3; RD1D = 32'h11; CtrlD = 24'h0ABCDE; RegWriteD = 1;
        rs1D = 5'd1; rs2D = 5'd2; PCD = 32'h200; PCPlus4D = 32'h204;
        applyStimulus();
        cmp("passRdE", 32'(rdE), 32'd3);
        cmp("passRD1E", RD1E, 32'h11);
        cmp("passCtrlE", 32'(CtrlE), 32'h0ABCDE);

        clearD(); validD = 1; LoadD = 1; RegWriteD = 1; rdD = 5'd5; CtrlD = 24'h000123;
        applyStimulus();
        clearD(); validD = 1; rs1D = 5'd5; rdD = 5'd6; RegWriteD = 1; RD1D = 32'h77;
        applyStimulus();
        cmp("bubbleValid", 32'(validE), 32'd0);
        cmp("bubbleCnt1", 32'(BubbleCnt), 32'd1);
        applyStimulus();
        cmp("afterBubbleRdE", 32'(rdE), 32'd6);

        clearD(); validD = 1; RegWriteW = 1; rdW = 5'd7; ResultW = 32'hDEAD; rs2D = 5'd7;
        applyStimulus();
        cmp("bypassRD2E", RD2E, 32'hDEAD);
        rdW = 5'd0; rs2D = 5'd0;
        applyStimulus();
        cmp("bypassX0", RD2E, 32'h0);

        clearD(); validD = 1; rs1D = 5'd4; rs2D = 5'd8; RD1D = 32'h1; RD2D = 32'h2;
        rdD = 5'd12; CtrlD = 24'h00F00F;
        applyStimulus();
        StallE = 1; RegWriteW = 1; rdW = 5'd4; ResultW = 32'h55;
        rs1D = 5'd20; RD1D = 32'h999; CtrlD = 24'h111111;
        applyStimulus();
        cmp("refreshRD1E", RD1E, 32'h55);
        cmp("heldCtrlE", 32'(CtrlE), 32'h00F00F);
        FlushE = 1;
        applyStimulus();
        cmp("flushStallCnt", 32'(BubbleCnt), 32'd2);

        clearD(); validD = 1; LoadD = 1; RegWriteD = 1; rdD = 5'd9;
        applyStimulus();
        clearD(); validD = 1; rs2D = 5'd9; StallE = 1;
        applyStimulus();
        cmp("stallHazardCnt", 32'(BubbleCnt), 32'd2);
        StallE = 0;
        applyStimulus();
        cmp("hazardAfterStall", 32'(BubbleCnt), 32'd3);

        clearD();
        for (int i = 0; i < 5; i++) begin
            FlushE = 1;
            applyStimulus();
        end
        cmp("saturated", 32'(BubbleCnt), 32'd3);

        clearD(); validD = 1; LoadD = 1; rdD = 5'd2;
        applyStimulus();
        StallE = 1; rs1D = 5'd2; RST = 1;
        applyStimulus();
        cmp("midStallReset", 32'(BubbleCnt), 32'd0);
        RST = 0;

        for (int i = 0; i < 40; i++) begin
            FlushE = ($urandom_range(0, 9) == 0); StallE = ($urandom_range(0, 4) == 0);
            validD = $urandom_range(0, 1); LoadD = $urandom_range(0, 1);
            RegWriteD = $urandom_range(0, 1); MemWriteD = $urandom_range(0, 1);
            rs1D = 5'($urandom_range(0, 3)); rs2D = 5'($urandom_range(0, 3));
            rdD = 5'($urandom_range(0, 3)); rdW = 5'($urandom_range(0, 3));
            RegWriteW = $urandom_range(0, 1); ResultW = $urandom;
            RD1D = $urandom; RD2D = $urandom; ImmExtD = $urandom;
            PCD = $urandom; PCPlus4D = PCD + 4; CtrlD = 24'($urandom);
            applyStimulus();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
